pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives STALL/FLUSH of the IF/ID latch, the ID/EX bubble, the back-end freeze, and front-end redirect.
- Arbitrates D-cache miss, branch mispredict, load-use hazard and I-cache miss by fixed priority.
- Tracks multi-cycle recovery and keeps stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 108 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: arbitrates D-cache miss,
// branch mispredict, load-use and I-cache miss, and keeps stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             DMISS,
   input  logic             IMISS,
   input  logic             LoadUse,
   input  logic             Mispredict,
   input  logic [31:0]      Mispredict_Target,
   output logic             STALL_IF,
   output logic             STALL_ID,
   output logic             STALL_BE,
   output logic             FLUSH_IFID,
   output logic             FLUSH_IDEX,
   output logic             Redirect_Valid,
   output logic [31:0]      Redirect_PC,
   output logic [CNT_W-1:0] Stall_Count,
   output logic [CNT_W-1:0] Flush_Count
);

   typedef enum logic {RUN, RECOVER} state_t;

   localparam logic [3:0] RC_INIT = 4'(FLUSH_CYCLES - 1);

   state_t      state;
   logic [3:0]  rc;
   logic        redir_done;
   logic [31:0] last_pc;
   logic        acc;

   // A mispredict already redirected while the branch sat frozen in EXE must not redirect again
   assign acc = Mispredict && !redir_done;

   always_comb begin
      STALL_IF       = 1'b0;
      STALL_ID       = 1'b0;
      STALL_BE       = 1'b0;
      FLUSH_IFID     = 1'b0;
      FLUSH_IDEX     = 1'b0;
      Redirect_Valid = 1'b0;
      Redirect_PC    = last_pc;
      if (RESET) begin
         Redirect_PC = 32'h0;
      end else if (DMISS) begin
         STALL_IF = 1'b1;
         STALL_ID = 1'b1;
         STALL_BE = 1'b1;
         if (acc) begin
            Redirect_Valid = 1'b1;
            Redirect_PC    = Mispredict_Target;
            FLUSH_IFID     = 1'b1;
         end
      end else if (acc) begin
         Redirect_Valid = 1'b1;
         Redirect_PC    = Mispredict_Target;
         FLUSH_IFID     = 1'b1;
         FLUSH_IDEX     = 1'b1;
      end else if (state == RECOVER) begin
         FLUSH_IFID = 1'b1;
         STALL_IF   = IMISS;
      end else if (LoadUse) begin
         STALL_IF   = 1'b1;
         STALL_ID   = 1'b1;
         FLUSH_IDEX = 1'b1;
      end else if (IMISS) begin
         STALL_IF   = 1'b1;
         FLUSH_IFID = 1'b1;
      end
   end

   // The recovery window counts down only while the back end is moving
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= RUN;
         rc          <= 4'd0;
         redir_done  <= 1'b0;
         last_pc     <= 32'h0;
         Stall_Count <= '0;
         Flush_Count <= '0;
      end else begin
         Stall_Count <= Stall_Count + {{(CNT_W-1){1'b0}}, STALL_IF};
         Flush_Count <= Flush_Count + {{(CNT_W-1){1'b0}}, acc};
         redir_done  <= DMISS && (redir_done || acc);
         if (acc) begin
            last_pc <= Mispredict_Target;
            if (FLUSH_CYCLES > 1) begin
               state <= RECOVER;
               rc    <= RC_INIT;
            end else begin
               state <= RUN;
               rc    <= 4'd0;
            end
         end else if (!DMISS && state == RECOVER) begin
            if (rc <= 4'd1) begin
               state <= RUN;
               rc    <= 4'd0;
            end else begin
               rc <= rc - 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (short window with narrow counters,
// single-cycle window with wide counters) checked against a rule-level reference model.
module tb_pipe_hazard_ctrl;

   typedef struct {
      logic [5:0]  ctl;
      logic [31:0] pc;
      logic [31:0] sc;
      logic [31:0] fc;
      bit          chkCnt;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset, dmiss, imiss, loadUse, mispredict;
   logic [31:0] target;

   logic        sIf0, sId0, sBe0, fIfid0, fIdex0, rv0;
   logic [31:0] rpc0;
   logic [3:0]  sc0, fc0;
   logic        sIf1, sId1, sBe1, fIfid1, fIdex1, rv1;
   logic [31:0] rpc1;
   logic [31:0] sc1, fc1;

   exp_t q0[$];
   exp_t q1[$];

   int testsRun = 0;
   int testsFailed = 0;

   // reference model state per instance: remaining flush-only cycles, redirect-taken-in-miss flag
   int          win[2];
   bit          rdone[2];
   logic [31:0] lastPc[2];
   longint      stallCnt[2];
   longint      flushCnt[2];
   bit          cntKnown[2];

   always #5 clock = ~clock;

   pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut0 (
      .CLK(clock), .RESET(reset), .DMISS(dmiss), .IMISS(imiss), .LoadUse(loadUse),
      .Mispredict(mispredict), .Mispredict_Target(target),
      .STALL_IF(sIf0), .STALL_ID(sId0), .STALL_BE(sBe0), .FLUSH_IFID(fIfid0),
      .FLUSH_IDEX(fIdex0), .Redirect_Valid(rv0), .Redirect_PC(rpc0),
      .Stall_Count(sc0), .Flush_Count(fc0)
   );

   pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut1 (
      .CLK(clock), .RESET(reset), .DMISS(dmiss), .IMISS(imiss), .LoadUse(loadUse),
      .Mispredict(mispredict), .Mispredict_Target(target),
      .STALL_IF(sIf1), .STALL_ID(sId1), .STALL_BE(sBe1), .FLUSH_IFID(fIfid1),
      .FLUSH_IDEX(fIdex1), .Redirect_Valid(rv1), .Redirect_PC(rpc1),
      .Stall_Count(sc1), .Flush_Count(fc1)
   );

   // Evaluate the priority rules for one cycle, then advance the model across the clock edge
   task automatic modelStep(input int k, input int fcyc, input int cw, output exp_t e);
      bit     acc;
      bit     sif, sid, sbe, fifid, fidex, rv;
      logic [31:0] pc;
      longint mask;
      mask = (longint'(1) << cw) - 1;
      e.chkCnt = cntKnown[k];
      e.sc = 32'(stallCnt[k]);
      e.fc = 32'(flushCnt[k]);
      if (reset) begin
         e.ctl = 6'b0;
         e.pc = 32'h0;
         win[k] = 0;
         rdone[k] = 0;
         lastPc[k] = 32'h0;
         stallCnt[k] = 0;
         flushCnt[k] = 0;
         cntKnown[k] = 1;
         return;
      end
      acc = mispredict && !rdone[k];
      {sif, sid, sbe, fifid, fidex, rv} = 6'b0;
      pc = lastPc[k];
      if (dmiss) begin
         {sif, sid, sbe} = 3'b111;
         if (acc) begin
            rv = 1; pc = target; fifid = 1;
         end
      end else if (acc) begin
         rv = 1; pc = target; fifid = 1; fidex = 1;
      end else if (win[k] > 0) begin
         fifid = 1; sif = imiss;
      end else if (loadUse) begin
         sif = 1; sid = 1; fidex = 1;
      end else if (imiss) begin
         sif = 1; fifid = 1;
      end
      e.ctl = {sif, sid, sbe, fifid, fidex, rv};
      e.pc = pc;
      if (sif) stallCnt[k] = (stallCnt[k] + 1) & mask;
      if (acc) begin
         flushCnt[k] = (flushCnt[k] + 1) & mask;
         lastPc[k] = target;
         win[k] = fcyc - 1;
      end else if (!dmiss && win[k] > 0) begin
         win[k] = win[k] - 1;
      end
      rdone[k] = dmiss && (rdone[k] || acc);
   endtask

   task automatic applyStimulus(input bit rst, input bit dm, input bit im, input bit lu,
                                input bit mp, input logic [31:0] tgt);
      exp_t e;
      @(posedge clock);
      #1;
      reset = rst; dmiss = dm; imiss = im; loadUse = lu; mispredict = mp; target = tgt;
      modelStep(0, 2, 4, e);
      q0.push_back(e);
      modelStep(1, 1, 32, e);
      q1.push_back(e);
   endtask

   task automatic checkOutput(input int k, input exp_t e, input logic [5:0] ctl,
                              input logic [31:0] pc, input logic [31:0] sc, input logic [31:0] fc);
      testsRun++;
      if (ctl !== e.ctl) begin
         testsFailed++;
         $display("[TB] FAIL dut%0d controls at %0t: got %b required %b (IF ID BE FIFID FIDEX RV)",
                  k, $time, ctl, e.ctl);
      end
      testsRun++;
      if (pc !== e.pc) begin
         testsFailed++;
         $display("[TB] FAIL dut%0d Redirect_PC at %0t: got %h required %h", k, $time, pc, e.pc);
      end
      if (e.chkCnt) begin
         testsRun++;
         if (sc !== e.sc || fc !== e.fc) begin
            testsFailed++;
            $display("[TB] FAIL dut%0d counters at %0t: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                     k, $time, sc, fc, e.sc, e.fc);
         end
      end
   endtask

   // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            checkOutput(0, e, {sIf0, sId0, sBe0, fIfid0, fIdex0, rv0}, rpc0, 32'(sc0), 32'(fc0));
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            checkOutput(1, e, {sIf1, sId1, sBe1, fIfid1, fIdex1, rv1}, rpc1, sc1, fc1);
         end
      end
   end

   initial begin
      reset = 1; dmiss = 0; imiss = 0; loadUse = 0; mispredict = 0; target = 32'h0;
      for (int k = 0; k < 2; k++) begin
         win[k] = 0; rdone[k] = 0; lastPc[k] = 0;
         stallCnt[k] = 0; flushCnt[k] = 0; cntKnown[k] = 0;
      end

      // reset with miss and mispredict pending, then a first free cycle
      applyStimulus(1, 1, 0, 0, 1, 32'h00400000);
      applyStimulus(1, 1, 0, 0, 1, 32'h00400000);
      applyStimulus(0, 0, 0, 0, 0, 32'h0);
      // single load-use bubble
      applyStimulus(0, 0, 0, 1, 0, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 32'h0);
      // mispredict, then LoadUse ignored inside the recovery window
      applyStimulus(0, 0, 0, 0, 1, 32'h00400100);
      applyStimulus(0, 0, 0, 1, 0, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 32'h0);
      // mispredict held through a 5-cycle D-cache miss and one cycle beyond it
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 1, 32'h00400200);
      applyStimulus(0, 0, 0, 0, 1, 32'h00400200);
      applyStimulus(0, 0, 0, 0, 0, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 32'h0);
      // load-use beats I-cache miss, then I-cache miss alone
      applyStimulus(0, 0, 1, 1, 0, 32'h0);
      applyStimulus(0, 0, 1, 0, 0, 32'h0);
      // counter wrap on the narrow instance: fresh reset then 17 stall cycles
      applyStimulus(1, 0, 0, 0, 0, 32'h0);
      for (int i = 0; i < 17; i++) applyStimulus(0, 0, 1, 0, 0, 32'h0);

      // randomized traffic with occasional resets and bursty misses
      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(0, 63) == 0,
                       $urandom_range(0, 3) == 0,
                       $urandom_range(0, 3) == 0,
                       $urandom_range(0, 4) == 0,
                       $urandom_range(0, 5) == 0,
                       $urandom());
      end

      @(posedge clock);
      @(negedge clock);
      #1;
      if (q0.size() != 0 || q1.size() != 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL scoreboard drain: got %0d/%0d entries left required 0", q0.size(), q1.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
